// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the writeback arbiter and its source FIFOs.
package wb_arbiter_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned NUM_SRC   = 3;

  // Writeback sources; the encoding doubles as the FIFO index.
  typedef enum logic [1:0] {
    SRC_X = 2'd0,
    SRC_Y = 2'd1,
    SRC_M = 2'd2
  } src_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] regdest;
    logic [WB_DATA_W-1:0] wbvalue;
  } wb_entry_t;

  // Round-robin successor in the order X -> Y -> M -> X.
  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_X:   return SRC_Y;
      SRC_Y:   return SRC_M;
      default: return SRC_X;
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding pending register writes for one execute unit.
// Exposes the head entry plus a per-slot valid/destination view so the
// arbiter can build the pending-destination mask. DEPTH must be a power of two.
module wb_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_dest_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] head_dest_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [DEPTH-1:0]  ent_valid_o,
  output logic [ADDR_W-1:0] ent_dest_o [DEPTH]
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [ADDR_W-1:0] dest_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              do_push, do_pop;

  // No pass-through: a full FIFO refuses a push even while it is being popped.
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_dest_o = dest_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign ent_valid_o = valid_q;
  assign ent_dest_o  = dest_q;

  // Next-state for pointers, occupancy and slot contents.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    dest_d   = dest_q;
    data_d   = data_q;
    if (do_push) begin
      wr_ptr_d          = wr_ptr_q + 1'b1;
      valid_d[wr_ptr_q] = 1'b1;
      dest_d[wr_ptr_q]  = push_dest_i;
      data_d[wr_ptr_q]  = push_data_i;
    end
    if (do_pop) begin
      rd_ptr_d          = rd_ptr_q + 1'b1;
      valid_d[rd_ptr_q] = 1'b0;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  // Slot storage; contents are qualified by valid_q so need no reset.
  always_ff @(posedge clk_i) begin
    dest_q <= dest_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three per-unit FIFOs drained one head per cycle into a
// registered register-file write port, plus pending-destination mask and stall.
// Optional macro WB_ARB_RR_EN selects round-robin (X->Y->M); otherwise fixed
// priority M > X > Y.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   x_wb_writereg,
  input  logic [ADDR_W-1:0]      x_wb_regdest,
  input  logic [DATA_W-1:0]      x_wb_wbvalue,
  output logic                   x_ready,
  input  logic                   y_wb_writereg,
  input  logic [ADDR_W-1:0]      y_wb_regdest,
  input  logic [DATA_W-1:0]      y_wb_wbvalue,
  output logic                   y_ready,
  input  logic                   m_wb_writereg,
  input  logic [ADDR_W-1:0]      m_wb_regdest,
  input  logic [DATA_W-1:0]      m_wb_wbvalue,
  output logic                   m_ready,
  output logic                   wb_reg_en,
  output logic [ADDR_W-1:0]      wb_reg_addr,
  output logic [DATA_W-1:0]      wb_reg_data,
  output logic [(1<<ADDR_W)-1:0] wb_pending_mask,
  output logic                   wb_stall
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [NUM_SRC-1:0] push_req, pop, full, empty, wr_req;
  logic [ADDR_W-1:0]  push_dest [NUM_SRC];
  logic [DATA_W-1:0]  push_data [NUM_SRC];
  logic [ADDR_W-1:0]  head_dest [NUM_SRC];
  logic [DATA_W-1:0]  head_data [NUM_SRC];
  logic [DEPTH-1:0]   ent_valid [NUM_SRC];
  logic [ADDR_W-1:0]  ent_dest  [NUM_SRC][DEPTH];

  logic               grant_valid;
  src_e               grant_src;

  logic               wb_en_q, wb_en_d;
  logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic [NumRegs-1:0] mask;

  assign x_ready = !full[SRC_X];
  assign y_ready = !full[SRC_Y];
  assign m_ready = !full[SRC_M];

  assign wr_req[SRC_X]    = x_wb_writereg;
  assign wr_req[SRC_Y]    = y_wb_writereg;
  assign wr_req[SRC_M]    = m_wb_writereg;
  assign push_dest[SRC_X] = x_wb_regdest;
  assign push_dest[SRC_Y] = y_wb_regdest;
  assign push_dest[SRC_M] = m_wb_regdest;
  assign push_data[SRC_X] = x_wb_wbvalue;
  assign push_data[SRC_Y] = y_wb_wbvalue;
  assign push_data[SRC_M] = m_wb_wbvalue;

  // Writes to r0 are accepted upstream but never buffered.
  always_comb begin
    push_req = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      push_req[s] = wr_req[s] && (push_dest[s] != '0);
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    wb_fifo #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_fifo (
      .clk_i      (clock),
      .rst_i      (reset),
      .push_i     (push_req[g]),
      .push_dest_i(push_dest[g]),
      .push_data_i(push_data[g]),
      .pop_i      (pop[g]),
      .full_o     (full[g]),
      .empty_o    (empty[g]),
      .head_dest_o(head_dest[g]),
      .head_data_o(head_data[g]),
      .ent_valid_o(ent_valid[g]),
      .ent_dest_o (ent_dest[g])
    );
  end

`ifdef WB_ARB_RR_EN
  src_e rr_q, rr_d;
  src_e cand;

  // Round-robin grant: search from rr_q; pointer moves past the winner only on a grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = rr_q;
    cand        = rr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_src   = cand;
      end
      cand = next_src(cand);
    end
    rr_d = grant_valid ? next_src(grant_src) : rr_q;
  end

  // Round-robin start pointer, X after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q <= SRC_X;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed-priority grant M > X > Y; Y may starve under sustained M/X traffic.
  always_comb begin
    grant_valid = 1'b1;
    grant_src   = SRC_X;
    if (!empty[SRC_M]) begin
      grant_src = SRC_M;
    end else if (!empty[SRC_X]) begin
      grant_src = SRC_X;
    end else if (!empty[SRC_Y]) begin
      grant_src = SRC_Y;
    end else begin
      grant_valid = 1'b0;
    end
  end
`endif

  // Pop the granted head and load it into the write port; addr/data hold when idle.
  always_comb begin
    pop       = '0;
    wb_en_d   = grant_valid;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (grant_valid) begin
      pop[grant_src] = 1'b1;
      wb_addr_d      = head_dest[grant_src];
      wb_data_d      = head_data[grant_src];
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Pending mask: every buffered destination plus the write in flight; r0 never pending.
  always_comb begin
    mask = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_valid[s][e]) begin
          mask[ent_dest[s][e]] = 1'b1;
        end
      end
    end
    if (wb_en_q) begin
      mask[wb_addr_q] = 1'b1;
    end
    mask[0] = 1'b0;
  end

  assign wb_reg_en       = wb_en_q;
  assign wb_reg_addr     = wb_addr_q;
  assign wb_reg_data     = wb_data_q;
  assign wb_pending_mask = mask;
  assign wb_stall        = |full;

`ifndef SYNTHESIS
  // Pushing into a full FIFO drops the entry; upstream must honour *_ready.
  a_x_push_ready: assert property (@(posedge clock) disable iff (reset)
    !(x_wb_writereg && !x_ready));
  a_y_push_ready: assert property (@(posedge clock) disable iff (reset)
    !(y_wb_writereg && !y_ready));
  a_m_push_ready: assert property (@(posedge clock) disable iff (reset)
    !(m_wb_writereg && !m_ready));
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter. Data values carry a source tag in [31:28]
// (1=X, 2=Y, 3=M) so the monitor can check per-source write order.
module tb_wb_arbiter;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              x_wb_writereg, y_wb_writereg, m_wb_writereg;
  logic [ADDR_W-1:0] x_wb_regdest, y_wb_regdest, m_wb_regdest;
  logic [DATA_W-1:0] x_wb_wbvalue, y_wb_wbvalue, m_wb_wbvalue;
  logic              x_ready, y_ready, m_ready;
  logic              wb_reg_en;
  logic [ADDR_W-1:0] wb_reg_addr;
  logic [DATA_W-1:0] wb_reg_data;
  logic [31:0]       wb_pending_mask;
  logic              wb_stall;

  always #5 clock = ~clock;

  wb_arbiter #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .x_wb_writereg  (x_wb_writereg),
    .x_wb_regdest   (x_wb_regdest),
    .x_wb_wbvalue   (x_wb_wbvalue),
    .x_ready        (x_ready),
    .y_wb_writereg  (y_wb_writereg),
    .y_wb_regdest   (y_wb_regdest),
    .y_wb_wbvalue   (y_wb_wbvalue),
    .y_ready        (y_ready),
    .m_wb_writereg  (m_wb_writereg),
    .m_wb_regdest   (m_wb_regdest),
    .m_wb_wbvalue   (m_wb_wbvalue),
    .m_ready        (m_ready),
    .wb_reg_en      (wb_reg_en),
    .wb_reg_addr    (wb_reg_addr),
    .wb_reg_data    (wb_reg_data),
    .wb_pending_mask(wb_pending_mask),
    .wb_stall       (wb_stall)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [36:0] q_x[$];
  logic [36:0] q_y[$];
  logic [36:0] q_m[$];
  logic [4:0]  wlog[$];
  logic        measuring = 1'b0;
  int          g_cnt[3];
  int          idle_cnt;

  logic [36:0] mon_got, mon_exp;
  logic [3:0]  mon_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: check each write against its source queue, then record new pushes.
  always @(negedge clock) begin
    if (wb_reg_en === 1'b1) begin
      mon_tag = wb_reg_data[31:28];
      mon_got = {wb_reg_addr, wb_reg_data};
      wlog.push_back(wb_reg_addr);
      if (measuring && mon_tag >= 4'd1 && mon_tag <= 4'd3) g_cnt[mon_tag-1]++;
      case (mon_tag)
        4'd1: begin
          check("x_sb_nonempty", 64'(q_x.size() != 0), 64'd1);
          mon_exp = (q_x.size() != 0) ? q_x.pop_front() : '0;
          check("x_write", 64'(mon_got), 64'(mon_exp));
        end
        4'd2: begin
          check("y_sb_nonempty", 64'(q_y.size() != 0), 64'd1);
          mon_exp = (q_y.size() != 0) ? q_y.pop_front() : '0;
          check("y_write", 64'(mon_got), 64'(mon_exp));
        end
        4'd3: begin
          check("m_sb_nonempty", 64'(q_m.size() != 0), 64'd1);
          mon_exp = (q_m.size() != 0) ? q_m.pop_front() : '0;
          check("m_write", 64'(mon_got), 64'(mon_exp));
        end
        default: begin
          n_total++;
          $display("FAIL write_tag: got write addr %0d data 0x%0h, expected no such write",
                   wb_reg_addr, wb_reg_data);
        end
      endcase
    end else if (measuring) begin
      idle_cnt++;
    end
    if (reset) begin
      q_x.delete();
      q_y.delete();
      q_m.delete();
    end else begin
      if (x_wb_writereg && x_wb_regdest != 0) q_x.push_back({x_wb_regdest, x_wb_wbvalue});
      if (y_wb_writereg && y_wb_regdest != 0) q_y.push_back({y_wb_regdest, y_wb_wbvalue});
      if (m_wb_writereg && m_wb_regdest != 0) q_m.push_back({m_wb_regdest, m_wb_wbvalue});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    x_wb_writereg = 1'b0; y_wb_writereg = 1'b0; m_wb_writereg = 1'b0;
    x_wb_regdest  = '0;   y_wb_regdest  = '0;   m_wb_regdest  = '0;
    x_wb_wbvalue  = '0;   y_wb_wbvalue  = '0;   m_wb_wbvalue  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  logic saw_x_not_ready, saw_stall;
  int   dxy, dym, dxm;

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) tick();
    reset = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ready_stall_en", 64'({x_ready, y_ready, m_ready, wb_stall, wb_reg_en}),
            64'b11100);
      check("idle_mask", 64'(wb_pending_mask), 64'd0);
    end

    // Single X push r5.
    x_wb_writereg = 1'b1; x_wb_regdest = 5'd5; x_wb_wbvalue = 32'h1000_00AA;
    tick();
    idle_inputs();
    check("x5_mask_buffered", 64'(wb_pending_mask), 64'h20);
    check("x5_no_write_yet", 64'(wb_reg_en), 64'd0);
    tick();
    check("x5_write", 64'({wb_reg_en, wb_reg_addr, wb_reg_data}), {1'b1, 5'd5, 32'h1000_00AA});
    check("x5_mask_outreg", 64'(wb_pending_mask), 64'h20);
    tick();
    check("x5_after_en", 64'(wb_reg_en), 64'd0);
    check("x5_mask_clear", 64'(wb_pending_mask), 64'd0);

    // Simultaneous X/Y/M pushes from a fresh reset.
    do_reset();
    wlog.delete();
    x_wb_writereg = 1'b1; x_wb_regdest = 5'd1; x_wb_wbvalue = 32'h1000_0001;
    y_wb_writereg = 1'b1; y_wb_regdest = 5'd2; y_wb_wbvalue = 32'h2000_0002;
    m_wb_writereg = 1'b1; m_wb_regdest = 5'd3; m_wb_wbvalue = 32'h3000_0003;
    tick();
    idle_inputs();
    check("sim_mask", 64'(wb_pending_mask), 64'h0E);
    repeat (5) tick();
    check("sim_write_count", 64'(wlog.size()), 64'd3);
`ifdef WB_ARB_RR_EN
    check("sim_order", 64'({wlog[0], wlog[1], wlog[2]}), 64'({5'd1, 5'd2, 5'd3}));
`else
    check("sim_order", 64'({wlog[0], wlog[1], wlog[2]}), 64'({5'd3, 5'd1, 5'd2}));
`endif

    // X and M push every cycle they are allowed; X must back up without loss.
    saw_x_not_ready = 1'b0;
    saw_stall       = 1'b0;
    for (int i = 0; i < 12; i++) begin
      x_wb_writereg = x_ready;
      x_wb_regdest  = 5'(8 + (i % 8));
      x_wb_wbvalue  = 32'h1000_0100 + 32'(i);
      m_wb_writereg = m_ready;
      m_wb_regdest  = 5'(16 + (i % 8));
      m_wb_wbvalue  = 32'h3000_0100 + 32'(i);
      tick();
      if (!x_ready) saw_x_not_ready = 1'b1;
      if (wb_stall) saw_stall = 1'b1;
    end
    idle_inputs();
    check("bp_x_ready_dropped", 64'(saw_x_not_ready), 64'd1);
    check("bp_stall_seen", 64'(saw_stall), 64'd1);
    repeat (8) tick();
    check("bp_drained", 64'(q_x.size() + q_m.size()), 64'd0);
    check("bp_idle_state", 64'({x_ready, m_ready, wb_stall, wb_reg_en}), 64'b1100);
    check("bp_mask_clear", 64'(wb_pending_mask), 64'd0);

    // Write to r0 from Y is accepted and discarded.
    check("r0_ready_before", 64'(y_ready), 64'd1);
    y_wb_writereg = 1'b1; y_wb_regdest = 5'd0; y_wb_wbvalue = 32'h0000_DEAD;
    tick();
    idle_inputs();
    check("r0_ready_after", 64'(y_ready), 64'd1);
    check("r0_mask", 64'(wb_pending_mask), 64'd0);
    tick();
    check("r0_no_write", 64'(wb_reg_en), 64'd0);
    check("r0_mask_later", 64'(wb_pending_mask), 64'd0);

    // Continuous traffic from all three sources.
    do_reset();
    for (int s = 0; s < 3; s++) g_cnt[s] = 0;
    idle_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      x_wb_writereg = x_ready; x_wb_regdest = 5'(8 + (i % 4));
      x_wb_wbvalue  = 32'h1000_0200 + 32'(i);
      y_wb_writereg = y_ready; y_wb_regdest = 5'(12 + (i % 4));
      y_wb_wbvalue  = 32'h2000_0200 + 32'(i);
      m_wb_writereg = m_ready; m_wb_regdest = 5'(16 + (i % 4));
      m_wb_wbvalue  = 32'h3000_0200 + 32'(i);
      if (i == 4) measuring = 1'b1;
      tick();
    end
    idle_inputs();
    measuring = 1'b0;
    check("flow_no_idle", 64'(idle_cnt), 64'd0);
`ifdef WB_ARB_RR_EN
    dxy = g_cnt[0] - g_cnt[1]; dym = g_cnt[1] - g_cnt[2]; dxm = g_cnt[0] - g_cnt[2];
    check("rr_fair_xy", 64'(dxy >= -1 && dxy <= 1), 64'd1);
    check("rr_fair_ym", 64'(dym >= -1 && dym <= 1), 64'd1);
    check("rr_fair_xm", 64'(dxm >= -1 && dxm <= 1), 64'd1);
`else
    check("fixed_m_every_cycle", 64'(g_cnt[2] > 20), 64'd1);
`endif
    repeat (12) tick();
    check("flow_drained", 64'(q_x.size() + q_y.size() + q_m.size()), 64'd0);
    check("flow_mask_clear", 64'(wb_pending_mask), 64'd0);

    // Reset while entries are buffered.
    x_wb_writereg = 1'b1; x_wb_regdest = 5'd4; x_wb_wbvalue = 32'h1000_0400;
    y_wb_writereg = 1'b1; y_wb_regdest = 5'd6; y_wb_wbvalue = 32'h2000_0600;
    m_wb_writereg = 1'b1; m_wb_regdest = 5'd7; m_wb_wbvalue = 32'h3000_0700;
    tick();
    x_wb_wbvalue = 32'h1000_0401;
    m_wb_wbvalue = 32'h3000_0701;
    y_wb_writereg = 1'b0;
    tick();
    idle_inputs();
    check("rst_mid_pending", 64'(wb_pending_mask != 0), 64'd1);
    reset = 1'b1;
    tick();
    check("rst_mid_outputs", 64'({x_ready, y_ready, m_ready, wb_stall, wb_reg_en}), 64'b11100);
    check("rst_mid_mask", 64'(wb_pending_mask), 64'd0);
    check("rst_mid_addr_data", 64'({wb_reg_addr, wb_reg_data}), 64'd0);
    reset = 1'b0;
    tick();
    check("rst_no_write_after", 64'(wb_reg_en), 64'd0);
    check("rst_mask_after", 64'(wb_pending_mask), 64'd0);
    repeat (3) tick();
    check("end_sb_empty", 64'(q_x.size() + q_y.size() + q_m.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
